ser_4b_tx: RTL and testbench

- Serial transmitter that reads a 4-bit parallel word, as held by the 4-bit latch register, and sends it over one line.
- Frame format: start bit (0), WIDTH data bits LSB first, stop bit (1).
- Each bit lasts DIV clock cycles.
- Sits downstream of the register stage; a matching serial receiver is the consumer.

---
 rtl/ser_pkg.sv | 28 ++
 rtl/ser_4b_tx_if.sv | 24 ++
 rtl/ser_bit_timer.sv | 39 +++
 rtl/ser_4b_tx.sv | 147 ++++++++++++++
 tb/tb_ser_4b_tx.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the serial transmitter and its future receiver.
//   ser_state_e   : frame FSM state encoding
//   LINE_IDLE/START_BIT/STOP_BIT : serial line levels
//   DEF_WIDTH/DEF_DIV : default data bits per frame, clocks per bit
//   div_cnt_width : width of a DIV counter, never less than one bit
package ser_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } ser_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DIV   = 4;

  // max(1, clog2(div)): DIV=1 and DIV=2 both fit in a single bit.
  function automatic int div_cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/ser_4b_tx_if.sv
// Parallel-side bus of the serial transmitter.
//   B     : word to transmit          (master -> slave)
//   load  : transmit request          (master -> slave)
//   ready : idle, able to accept      (slave -> master)
//   busy  : frame in progress         (slave -> master)
//   sout  : serial line, idles high   (slave -> master)
//   done  : one-cycle end-of-frame    (slave -> master)
interface ser_4b_tx_if
  import ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] B;
  logic             load;
  logic             ready;
  logic             busy;
  logic             sout;
  logic             done;

  modport master (output B, load, input ready, busy, sout, done);
  modport slave  (input B, load, output ready, busy, sout, done);

endinterface

// File: rtl/ser_bit_timer.sv
// Bit-period timer: counts DIV clocks and raises tick on the last cycle of
// each bit period. A synchronous clear holds the count at zero.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (count held at 0)
//   tick       : high during the final cycle of a bit period
module ser_bit_timer
  import ser_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = div_cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  // NOTE: state flops use non-blocking assignment so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ser_4b_tx.sv
// Serial transmitter: accepts a parallel word when idle and sends it as
// start bit (0), WIDTH data bits LSB first, [even parity], stop bit (1),
// each bit lasting DIV clocks. All outputs are registered.
//   clk, rst_n : clock, asynchronous active-low reset (aborts a frame)
//   bus        : slave side of ser_4b_tx_if (B, load in; ready, busy,
//                sout, done out)
// Build option: define SER_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
module ser_4b_tx
  import ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input logic        clk,
  input logic        rst_n,
  ser_4b_tx_if.slave bus
);

  localparam int            BW       = $clog2(WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             sout_q, sout_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SER_TX_PARITY_EN
  logic             par_q, par_d;
`endif
  logic             tick;

  // Held clear while idle, so START begins at count 0. Every other state
  // change happens on tick, where the counter wraps to 0 on its own.
  ser_bit_timer #(.DIV(DIV)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sout_d    = sout_q;
    done_d    = 1'b0;
`ifdef SER_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        sout_d = LINE_IDLE;
        if (bus.load) begin
          shreg_d   = bus.B;
          bit_cnt_d = '0;
          state_d   = START;
          sout_d    = START_BIT;
`ifdef SER_TX_PARITY_EN
          par_d     = ^bus.B;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          sout_d  = shreg_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef SER_TX_PARITY_EN
            state_d = PARITY;
            sout_d  = par_q;
`else
            state_d = STOP;
            sout_d  = STOP_BIT;
`endif
          end else begin
            shreg_d   = shreg_q >> 1;
            sout_d    = shreg_d[0];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef SER_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          sout_d  = STOP_BIT;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          sout_d  = LINE_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        sout_d  = LINE_IDLE;
      end
    endcase
    // Status follows the next state so it changes on the same edge.
    ready_d = (state_d == IDLE);
    busy_d  = ~ready_d;
  end

  // NOTE: the shift register is a plain datapath register, so it is reset
  // with everything else rather than left unreset like a RAM array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sout_q    <= LINE_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SER_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sout_q    <= sout_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SER_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign bus.sout  = sout_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_ser_4b_tx.sv
// Scoreboard bench for ser_4b_tx: stimulus pushes each accepted word into a
// queue; a monitor detects each start bit, pops the word and checks every
// bit period, the done cycle, frame length and inter-frame gap.
module tb_ser_4b_tx;

  localparam int WIDTH = 4;
  localparam int DIV   = 4;
`ifdef SER_TX_PARITY_EN
  localparam int NBITS     = WIDTH + 3;
  localparam int FRAME_CYC = 28;
`else
  localparam int NBITS     = WIDTH + 2;
  localparam int FRAME_CYC = 24;
`endif
  // {sout, busy, ready, done}
  localparam logic [3:0] IDLE_SMP = 4'b1010;
  localparam logic [3:0] DONE_SMP = 4'b1011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ser_4b_tx_if #(.WIDTH(WIDTH)) bus ();

  ser_4b_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [WIDTH-1:0] exp_q[$];
  int cyc = 0;
  int mon_pos = -1;
  int frames_done = 0;
  int last_done_cyc = -100;
  int start_cyc = 0;
  int last_gap = 0;
  int last_len = 0;
  logic [WIDTH-1:0] mon_word;
  logic [3:0] smp, bad_smp, exp_smp;
  logic bit_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line level of frame bit idx for word w.
  function automatic logic frame_bit(input logic [WIDTH-1:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= WIDTH) return w[idx-1];
`ifdef SER_TX_PARITY_EN
    if (idx == WIDTH + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      smp = {bus.sout, bus.busy, bus.ready, bus.done};
      if (!rst_n) begin
        mon_pos = -1;
      end else if (mon_pos < 0) begin
        if (bus.sout === 1'b0) begin
          if (exp_q.size() == 0) begin
            check("frame start without request", 32'(smp), 32'(IDLE_SMP));
          end else begin
            mon_word  = exp_q.pop_front();
            mon_pos   = 0;
            bit_bad   = 1'b0;
            last_gap  = cyc - last_done_cyc;
            start_cyc = cyc;
          end
        end else if (bus.done !== 1'b0) begin
          check("done while idle", 32'(smp), 32'(IDLE_SMP));
        end
      end
      if (rst_n && mon_pos >= 0) begin
        if (mon_pos < NBITS * DIV) begin
          exp_smp = {frame_bit(mon_word, mon_pos / DIV), 3'b100};
          if (smp !== exp_smp && !bit_bad) begin
            bit_bad = 1'b1;
            bad_smp = smp;
          end
          if (mon_pos % DIV == DIV - 1) begin
            check($sformatf("word %h bit %0d", mon_word, mon_pos / DIV),
                  32'(bit_bad ? bad_smp : smp), 32'(exp_smp));
            bit_bad = 1'b0;
          end
          mon_pos++;
        end else begin
          check($sformatf("word %h done cycle", mon_word), 32'(smp), 32'(DONE_SMP));
          last_len      = cyc - start_cyc;
          last_done_cyc = cyc;
          frames_done++;
          mon_pos       = -1;
        end
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] w);
    @(negedge clk);
    bus.B    = w;
    bus.load = 1'b1;
    exp_q.push_back(w);
    @(negedge clk);
    bus.load = 1'b0;
    bus.B    = ~w;  // changing B after the accept edge must not matter
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((mon_pos >= 0 || exp_q.size() != 0 || bus.ready !== 1'b1) && n < 200);
    check({name, " reached idle"}, 32'(n < 200), 32'd1);
  endtask

  initial begin
    int n;
    int exp_frames;
    exp_frames = 0;
    bus.B    = '0;
    bus.load = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset outputs", 32'({bus.sout, bus.busy, bus.ready, bus.done}), 32'(IDLE_SMP));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("idle after release", 32'({bus.sout, bus.busy, bus.ready, bus.done}), 32'(IDLE_SMP));

    // Single frame
    send(4'b1011); exp_frames++;
    wait_idle("single");
    check("single frame length", 32'(last_len), 32'(FRAME_CYC));

    // Load while busy is ignored
    send(4'b0110); exp_frames++;
    repeat (5) @(negedge clk);
    bus.B    = 4'b0000;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    wait_idle("busy ignore");
    repeat (2 * FRAME_CYC) @(negedge clk);
    #1;
    check("frames after busy ignore", 32'(frames_done), 32'(exp_frames));

    // Back-to-back with load held high
    @(negedge clk);
    bus.B    = 4'b0101;
    bus.load = 1'b1;
    exp_q.push_back(4'b0101); exp_frames++;
    @(negedge clk);
    bus.B = 4'b1110;
    exp_q.push_back(4'b1110); exp_frames++;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (bus.ready !== 1'b1 && n < 100);
    check("b2b first frame ends", 32'(n < 100), 32'd1);
    @(negedge clk);
    bus.load = 1'b0;
    wait_idle("back-to-back");
    check("b2b idle gap", 32'(last_gap), 32'd1);
    check("b2b second length", 32'(last_len), 32'(FRAME_CYC));

    // Reset during data bit 2 (frame bit index 3)
    send(4'b1011);
    repeat (13) @(negedge clk);
    #2;
    check("line low before abort", 32'(bus.sout), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async abort outputs", 32'({bus.sout, bus.busy, bus.ready, bus.done}), 32'(IDLE_SMP));
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    send(4'b0001); exp_frames++;
    wait_idle("after abort");
    check("frames after abort", 32'(frames_done), 32'(exp_frames));

`ifdef SER_TX_PARITY_EN
    send(4'b1011); exp_frames++;
    wait_idle("parity 1");
    check("parity frame length", 32'(last_len), 32'd28);
    send(4'b0011); exp_frames++;
    wait_idle("parity 0");
`endif

    repeat (4) @(negedge clk);
    #1;
    check("queue drained", 32'(exp_q.size()), 32'd0);
    check("total frames", 32'(frames_done), 32'(exp_frames));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
